// File: rtl/booth_mult_seq.sv
// Sequential radix-4 Booth multiplier, signed or unsigned per operation, START/END_MULT handshake.
// Optional macro BOOTH_EARLY_TERM_EN: a zero operand completes with latency 1.
module booth_mult_seq #(
  parameter int tamano = 8
) (
  input  logic                  CLOCK,
  input  logic                  RESET,
  input  logic                  START,
  input  logic                  SIGNED_MODE,
  input  logic [tamano-1:0]     A,
  input  logic [tamano-1:0]     B,
  output logic [2*tamano-1:0]   S,
  output logic                  END_MULT,
  output logic                  BUSY
);

  localparam int XW = tamano + 2;
  localparam int PW = tamano + 3;
  localparam int AW = 2*tamano + 4;
  localparam int CW = $clog2(tamano/2 + 2);
  localparam logic [CW-1:0] LAST_S = CW'(tamano/2 - 1);
  localparam logic [CW-1:0] LAST_U = CW'(tamano/2);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t              state;
  logic [XW-1:0]       mcand;
  logic [XW:0]         mplier;
  logic [AW-1:0]       acc;
  logic [CW-1:0]       count;
  logic                mode;

  logic [XW-1:0]       a_ext;
  logic [XW-1:0]       b_ext;
  logic [PW-1:0]       mcand_w;
  logic [PW-1:0]       pp;
  logic [AW-1:0]       acc_shr;
  logic [AW-1:0]       acc_next;
  logic [2*tamano-1:0] result;
  logic                last;

  always_comb begin
    a_ext   = {{2{SIGNED_MODE & A[tamano-1]}}, A};
    b_ext   = {{2{SIGNED_MODE & B[tamano-1]}}, B};
    mcand_w = {mcand[XW-1], mcand};
    case (mplier[2:0])
      3'b001, 3'b010: pp = mcand_w;
      3'b011:         pp = {mcand_w[PW-2:0], 1'b0};
      3'b100:         pp = '0 - {mcand_w[PW-2:0], 1'b0};
      3'b101, 3'b110: pp = '0 - mcand_w;
      default:        pp = '0;
    endcase
    // Shift-then-add at weight 2^(tamano+1) leaves the product scaled by
    // 2^(tamano+3-2N): x8 with N=tamano/2 digits, x2 with the extra unsigned digit.
    acc_shr  = $signed(acc) >>> 2;
    acc_next = acc_shr + {pp, {(tamano+1){1'b0}}};
    result   = mode ? acc_next[2*tamano+2:3] : acc_next[2*tamano:1];
    last     = (count == (mode ? LAST_S : LAST_U));
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state    <= IDLE;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      count    <= '0;
      mode     <= 1'b0;
      S        <= '0;
      END_MULT <= 1'b0;
      BUSY     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (START) begin
            mcand  <= a_ext;
            mplier <= {b_ext, 1'b0};
            acc    <= '0;
            count  <= '0;
            mode   <= SIGNED_MODE;
            BUSY   <= 1'b1;
            state  <= CALC;
`ifdef BOOTH_EARLY_TERM_EN
            // Zero operand: one CALC pass with a zero multiplicand finishes on the next edge.
            if (A == '0 || B == '0) begin
              mcand <= '0;
              count <= SIGNED_MODE ? LAST_S : LAST_U;
            end
`endif
          end
        end
        CALC: begin
          acc    <= acc_next;
          mplier <= $signed(mplier) >>> 2;
          count  <= count + CW'(1);
          if (last) begin
            S        <= result;
            END_MULT <= 1'b1;
            state    <= FIN;
          end
        end
        FIN: begin
          END_MULT <= 1'b0;
          BUSY     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Testbench for booth_mult_seq (tamano = 8): vector table, busy/abort sequences, random ops vs. arithmetic model.
module tb_booth_mult_seq;

  localparam int W = 8;
`ifdef BOOTH_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  localparam int ZLAT_S = EARLY ? 1 : W/2;
  localparam int ZLAT_U = EARLY ? 1 : W/2 + 1;

  logic           CLOCK = 1'b0;
  logic           RESET = 1'b1;
  logic           START = 1'b0;
  logic           SIGNED_MODE = 1'b0;
  logic [W-1:0]   A = '0;
  logic [W-1:0]   B = '0;
  logic [2*W-1:0] S;
  logic           END_MULT;
  logic           BUSY;

  int             checks = 0;
  int             errors = 0;
  logic [2*W-1:0] last_s = '0;

  booth_mult_seq #(.tamano(W)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .START(START), .SIGNED_MODE(SIGNED_MODE),
    .A(A), .B(B), .S(S), .END_MULT(END_MULT), .BUSY(BUSY)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct {
    logic           sm;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] s;
    int             lat;
  } vec_t;

  function automatic logic [2*W-1:0] ref_prod(input logic sm, input logic [W-1:0] a, input logic [W-1:0] b);
    longint x, y, p;
    if (sm) begin
      x = longint'($signed(a));
      y = longint'($signed(b));
    end else begin
      x = longint'(a);
      y = longint'(b);
    end
    p = x * y;
    return p[2*W-1:0];
  endfunction

  function automatic int ref_lat(input logic sm, input logic [W-1:0] a, input logic [W-1:0] b);
    if (EARLY && (a == '0 || b == '0)) return 1;
    return sm ? W/2 : W/2 + 1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic start_op(input logic sm, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge CLOCK);
    START = 1'b1; SIGNED_MODE = sm; A = a; B = b;
    @(posedge CLOCK);
    #1;
    START = 1'b0;
    SIGNED_MODE = 1'($urandom);
    A = W'($urandom);
    B = W'($urandom);
  endtask

  // Called 1ns after the accept edge; returns edges until END_MULT is seen.
  task automatic collect(input bit noise, output int lat, output logic [2*W-1:0] s,
                         output bit busy_ok, output bit hold_ok);
    lat = 0; busy_ok = 1'b1; hold_ok = 1'b1;
    if (BUSY !== 1'b1) busy_ok = 1'b0;
    while (lat < 12) begin
      @(negedge CLOCK);
      if (noise) begin
        START = 1'b1; SIGNED_MODE = 1'($urandom); A = W'($urandom); B = W'($urandom);
      end
      @(posedge CLOCK);
      #1;
      lat++;
      if (BUSY !== 1'b1) busy_ok = 1'b0;
      if (END_MULT === 1'b1) break;
      if (S !== last_s) hold_ok = 1'b0;
    end
    s = S;
  endtask

  task automatic check_done(input string name, input logic [2*W-1:0] exp_s, input int exp_lat,
                            input int lat, input logic [2*W-1:0] s, input bit busy_ok, input bit hold_ok);
    chk({name, " S"}, 32'(s), 32'(exp_s));
    chk({name, " latency"}, 32'(lat), 32'(exp_lat));
    chk({name, " busy high"}, 32'(busy_ok), 32'd1);
    chk({name, " S hold"}, 32'(hold_ok), 32'd1);
    last_s = exp_s;
  endtask

  task automatic run_op(input string name, input logic sm, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] exp_s, input int exp_lat);
    int lat; logic [2*W-1:0] s; bit busy_ok, hold_ok;
    start_op(sm, a, b);
    collect(1'b0, lat, s, busy_ok, hold_ok);
    check_done(name, exp_s, exp_lat, lat, s, busy_ok, hold_ok);
    @(posedge CLOCK);
    #1;
    chk({name, " pulse end"}, 32'(END_MULT), 32'd0);
    chk({name, " busy end"}, 32'(BUSY), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl[13];
    int lat, pulses;
    logic [2*W-1:0] s;
    bit busy_ok, hold_ok;
    logic sm;
    logic [W-1:0] a, b;

    tbl[0]  = '{1'b1, 8'h80, 8'h80, 16'h4000, W/2};
    tbl[1]  = '{1'b0, 8'hFF, 8'hFF, 16'hFE01, W/2 + 1};
    tbl[2]  = '{1'b1, 8'hFF, 8'hFF, 16'h0001, W/2};
    tbl[3]  = '{1'b1, 8'h80, 8'h7F, 16'hC080, W/2};
    tbl[4]  = '{1'b1, 8'hFF, 8'h01, 16'hFFFF, W/2};
    tbl[5]  = '{1'b0, 8'h80, 8'h80, 16'h4000, W/2 + 1};
    tbl[6]  = '{1'b1, 8'h7F, 8'h7F, 16'h3F01, W/2};
    tbl[7]  = '{1'b0, 8'hC8, 8'h03, 16'h0258, W/2 + 1};
    tbl[8]  = '{1'b1, 8'h00, 8'h4D, 16'h0000, ZLAT_S};
    tbl[9]  = '{1'b0, 8'h4D, 8'h00, 16'h0000, ZLAT_U};
    tbl[10] = '{1'b1, 8'h80, 8'h01, 16'hFF80, W/2};
    tbl[11] = '{1'b0, 8'h80, 8'hFF, 16'h7F80, W/2 + 1};
    tbl[12] = '{1'b1, 8'h7F, 8'h80, 16'hC080, W/2};

    #3 RESET = 1'b0;
    #1;
    chk("reset S", 32'(S), 32'd0);
    chk("reset END_MULT", 32'(END_MULT), 32'd0);
    chk("reset BUSY", 32'(BUSY), 32'd0);
    repeat (2) @(negedge CLOCK);
    RESET = 1'b1;

    for (int i = 0; i < 13; i++)
      run_op($sformatf("vec%0d", i), tbl[i].sm, tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].lat);

    // START held with changing operands while busy: only the first operands count.
    start_op(1'b1, 8'h80, 8'h7F);
    collect(1'b1, lat, s, busy_ok, hold_ok);
    check_done("busy-start", 16'hC080, W/2, lat, s, busy_ok, hold_ok);
    @(negedge CLOCK);
    START = 1'b1; SIGNED_MODE = 1'b0; A = 8'd3; B = 8'd5;
    @(posedge CLOCK);
    #1;
    chk("fin ignores start", 32'(BUSY), 32'd0);
    chk("fin pulse end", 32'(END_MULT), 32'd0);
    @(posedge CLOCK);
    #1;
    chk("idle accepts held start", 32'(BUSY), 32'd1);
    START = 1'b0; A = W'($urandom); B = W'($urandom);
    collect(1'b0, lat, s, busy_ok, hold_ok);
    check_done("held-start op", 16'd15, W/2 + 1, lat, s, busy_ok, hold_ok);
    @(posedge CLOCK);
    #1;

    // Reset during the second CALC cycle aborts without a completion pulse.
    start_op(1'b1, 8'h0A, 8'h14);
    @(posedge CLOCK);
    #2 RESET = 1'b0;
    #1;
    chk("abort S", 32'(S), 32'd0);
    chk("abort END_MULT", 32'(END_MULT), 32'd0);
    chk("abort BUSY", 32'(BUSY), 32'd0);
    last_s = '0;
    repeat (2) @(posedge CLOCK);
    @(negedge CLOCK);
    RESET = 1'b1;
    pulses = 0;
    repeat (8) begin
      @(posedge CLOCK);
      #1;
      if (END_MULT === 1'b1 || BUSY === 1'b1) pulses++;
    end
    chk("no activity after abort", 32'(pulses), 32'd0);
    run_op("post-abort", 1'b0, 8'd9, 8'd11, 16'd99, W/2 + 1);

    for (int i = 0; i < 150; i++) begin
      sm = 1'($urandom);
      a  = W'($urandom);
      b  = W'($urandom);
      if ($urandom_range(0, 9) == 0) a = '0;
      if ($urandom_range(0, 9) == 0) b = '0;
      run_op($sformatf("rand%0d sm=%0d a=%0h b=%0h", i, sm, a, b), sm, a, b, ref_prod(sm, a, b), ref_lat(sm, a, b));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
